// File: rtl/regfile_dump_if.sv
// Beat stream from the register-file dump engine to its consumer.
//   out_valid : beat present (source -> sink)
//   out_ready : sink accepts the beat (sink -> source)
//   out_idx   : register index of the beat
//   out_data  : register value of the beat
interface regfile_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [63:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register file read port from X0 upward,
// streams (index, value) beats over a valid/ready link, keeps a wrapping
// 64-bit checksum of accepted beats and pulses done after the last beat.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : begin a scan (only honoured when idle)
//   ra / rd      : register file read address / combinational read data
//   stream       : beat output (master side of regfile_dump_if)
//   busy         : high whenever not idle
//   done         : one-cycle pulse after the final beat is accepted
//   checksum     : mod-2^64 sum of accepted beats of current/last scan
module regfile_dump #(
    parameter int unsigned NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [4:0]            ra,
    input  logic [63:0]           rd,
    regfile_dump_if.master        stream,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           checksum
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // End of scan is found by comparing against the last index, so idx
    // never has to wrap even when NREGS is 32.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            checksum_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            checksum_q <= checksum_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        checksum_d = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d      = '0;
                    checksum_d = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                // ra has held idx for a full cycle, so rd has settled
                out_data_d = rd;
                out_idx_d  = idx_q;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (stream.out_ready) begin
                    checksum_d = checksum_q + out_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state decode
        valid_d = (state_d == S_SEND);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign ra              = idx_q;
    assign stream.out_valid = valid_q;
    assign stream.out_idx   = out_idx_q;
    assign stream.out_data  = out_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign checksum        = checksum_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (32 and 2 registers) fed by array
// register-file models; scans are checked against the expected ordered
// list of (index, value) beats and their wrapping sum.
module tb_regfile_dump;

    logic        clk;
    logic        reset;
    logic        start_drv;
    logic        ready_drv;
    bit          cur;          // 0: 32-register instance, 1: 2-register instance

    logic [63:0] rf32 [32];
    logic [63:0] rf2  [32];

    logic [4:0]  ra32, ra2;
    logic [63:0] rd32, rd2;
    logic        busy32, busy2, done32, done2;
    logic [63:0] cks32, cks2;
    logic        start32, start2;

    regfile_dump_if if32 ();
    regfile_dump_if if2 ();

    assign if32.out_ready = ready_drv;
    assign if2.out_ready  = ready_drv;
    assign start32 = cur ? 1'b0 : start_drv;
    assign start2  = cur ? start_drv : 1'b0;
    assign rd32 = rf32[ra32];
    assign rd2  = rf2[ra2];

    regfile_dump #(.NREGS(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .ra(ra32), .rd(rd32),
        .stream(if32), .busy(busy32), .done(done32), .checksum(cks32)
    );

    regfile_dump #(.NREGS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ra(ra2), .rd(rd2),
        .stream(if2), .busy(busy2), .done(done2), .checksum(cks2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        m_valid, m_busy, m_done;
    logic [4:0]  m_idx, m_ra;
    logic [63:0] m_data, m_cks;
    always_comb begin
        m_valid = cur ? if2.out_valid : if32.out_valid;
        m_idx   = cur ? if2.out_idx   : if32.out_idx;
        m_data  = cur ? if2.out_data  : if32.out_data;
        m_busy  = cur ? busy2         : busy32;
        m_done  = cur ? done2         : done32;
        m_cks   = cur ? cks2          : cks32;
        m_ra    = cur ? ra2           : ra32;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_val(input int i);
        return cur ? rf2[i] : rf32[i];
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ra"},    64'(m_ra), 64'd0);
        chk({tag, "_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_idx"},   64'(m_idx), 64'd0);
        chk({tag, "_data"},  m_data, 64'd0);
        chk({tag, "_busy"},  64'(m_busy), 64'd0);
        chk({tag, "_done"},  64'(m_done), 64'd0);
        chk({tag, "_cks"},   m_cks, 64'd0);
    endtask

    // One scan; -1 disables bp_beat/start_beat/abort_beat.
    task automatic scan(input bit sel, input int pct, input int bp_beat,
                        input int start_beat, input int abort_beat, input bit exact);
        int n, beats, cyc, bp_cnt;
        bit aborted;
        logic [63:0] exp_sum;
        cur = sel;
        n = sel ? 2 : 32;
        exp_sum = '0;
        for (int i = 0; i < n; i++) exp_sum += ref_val(i);
        beats = 0; cyc = 0; bp_cnt = 0; aborted = 0;

        start_drv = 1'b1;
        @(posedge clk);               // edge E
        #1 start_drv = 1'b0;
        @(negedge clk);
        chk("busy_after_E", 64'(m_busy), 64'd1);
        chk("valid_after_E", 64'(m_valid), 64'd0);
        @(posedge clk); cyc = 1; #1;

        while (beats < n && !aborted) begin
            if (cyc > 1000) begin
                chk("scan_timeout_beats", 64'(beats), 64'(n));
                break;
            end
            ready_drv = ($urandom_range(99) < 32'(pct));
            if (beats == bp_beat && bp_cnt < 5) ready_drv = 1'b0;
            start_drv = (beats == start_beat);
            @(negedge clk);
            chk("done_mid_scan", 64'(m_done), 64'd0);
            if (m_valid) begin
                chk($sformatf("beat%0d_idx", beats), 64'(m_idx), 64'(beats));
                chk($sformatf("beat%0d_data", beats), m_data, ref_val(beats));
                if (beats == bp_beat && !ready_drv) bp_cnt++;
                if (beats == abort_beat) begin
                    reset = 1'b1;
                    #1;
                    chk("abort_valid", 64'(m_valid), 64'd0);
                    chk("abort_busy", 64'(m_busy), 64'd0);
                    chk("abort_cks", m_cks, 64'd0);
                    aborted = 1;
                end else if (ready_drv) begin
                    beats++;
                end
            end
            if (!aborted) begin
                @(posedge clk); cyc++; #1;
            end
        end
        start_drv = 1'b0;
        ready_drv = 1'b0;

        if (aborted) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("post_abort_done", 64'(m_done), 64'd0);
                chk("post_abort_busy", 64'(m_busy), 64'd0);
            end
        end else begin
            @(negedge clk);
            chk("done_pulse", 64'(m_done), 64'd1);
            chk("done_busy", 64'(m_busy), 64'd1);
            chk("done_valid", 64'(m_valid), 64'd0);
            if (exact) chk("done_edge_offset", 64'(cyc), 64'(2 * n));
            if (bp_beat >= 0) chk("bp_cycles", 64'(bp_cnt), 64'd5);
            @(negedge clk);
            chk("done_cleared", 64'(m_done), 64'd0);
            chk("busy_cleared", 64'(m_busy), 64'd0);
            chk("checksum", m_cks, exp_sum);
            repeat (3) begin
                @(negedge clk);
                chk("idle_after_scan", 64'(m_busy), 64'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start_drv = 1'b0;
        ready_drv = 1'b0;
        cur = 0;
        for (int i = 0; i < 32; i++) begin
            rf32[i] = {$urandom, $urandom};
            rf2[i]  = {$urandom, $urandom};
        end
        rf32[31] = '0;

        // Reset values on both instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        cur = 0; chk_reset_vals("rst32");
        cur = 1; chk_reset_vals("rst2");
        reset = 1'b0;
        @(negedge clk);
        cur = 0; chk_reset_vals("rel32");
        @(posedge clk); #1;

        // First scan after reset, random backpressure
        scan(0, 70, -1, -1, -1, 0);

        // Xi = i, X31 = 0, ready held high
        for (int i = 0; i < 31; i++) rf32[i] = 64'(i);
        rf32[31] = '0;
        scan(0, 100, -1, -1, -1, 1);
        cur = 0;
        chk("checksum_465", m_cks, 64'h1D1);
        @(posedge clk); #1;

        // Backpressure on beat 4
        for (int i = 0; i < 31; i++) rf32[i] = {$urandom, $urandom};
        rf32[4] = 64'hFFF;
        scan(0, 100, 4, -1, -1, 1'b0);

        // Checksum wrap with two registers
        for (int i = 0; i < 32; i++) rf2[i] = '0;
        rf2[0] = '1;
        rf2[1] = '1;
        scan(1, 100, -1, -1, -1, 1);
        cur = 1;
        chk("checksum_wrap", m_cks, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk); #1;

        // Start during beat 10 is ignored
        for (int i = 0; i < 31; i++) rf32[i] = {$urandom, $urandom};
        scan(0, 60, -1, 10, -1, 0);

        // Reset during beat 20, then a clean scan from index 0
        scan(0, 80, -1, -1, 20, 0);
        scan(0, 100, -1, -1, -1, 1);

        // Random traffic on both sizes
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                rf32[i] = {$urandom, $urandom};
                rf2[i]  = {$urandom, $urandom};
            end
            scan(0, 40, -1, -1, -1, 0);
            scan(1, 50, -1, -1, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
